// File: rtl/traffic_pkg.sv
// Shared phase encoding and default timing for the intersection timer.
// The phase order wraps from ALL_RED_B back to NS_GREEN.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } phase_e;

  localparam int DEF_GREEN_MIN = 8;
  localparam int DEF_GREEN_MAX = 20;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 1;
  localparam int DEF_CNT_W     = 5;

  function automatic phase_e next_phase(
    input phase_e p
  );
    phase_e n;
    unique case (p)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALL_RED_A;
      ALL_RED_A: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALL_RED_B;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_phase_timer_ped_latch.sv
// Per-direction pedestrian request latch and walk indication.
// A press coinciding with the grant strobe is served immediately.
module ped_latch (
  input  logic clk,
  input  logic reset,
  input  logic press,
  input  logic grant,
  input  logic leave,
  output logic pending,
  output logic walk
);

  logic pend_q, pend_d;
  logic walk_q, walk_d;

  always_comb begin
    pend_d = pend_q | press;
    walk_d = walk_q;
    if (grant) begin
      walk_d = pend_q | press;
      pend_d = 1'b0;
    end else if (leave) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      walk_q <= walk_d;
    end
  end

  assign pending = pend_q;
  assign walk    = walk_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Six-phase intersection timer with demand-actuated greens.
// Emits a one-cycle advance pulse when a new phase becomes visible.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             hold,
  input  logic             car_ns,
  input  logic             car_ew,
  input  logic             ped_ns,
  input  logic             ped_ew,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             advance,
  output logic             walk_ns,
  output logic             walk_ew,
  output logic [1:0]       ped_pending
);

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] EARLY_C =
    CNT_W'(GREEN_MAX - GREEN_MIN + 1);
  localparam logic [CNT_W-1:0] YEL_C =
    CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_C =
    CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] ONE_C =
    CNT_W'(1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             adv_q, adv_d;

  logic qual, done, bad;
  logic pend_ns, pend_ew;
  logic grant_ns, grant_ew;
  logic leave_ns, leave_ew;

  function automatic logic [CNT_W-1:0] dwell(
    input phase_e p
  );
    logic [CNT_W-1:0] d;
    unique case (p)
      NS_GREEN, EW_GREEN:   d = MAX_C;
      NS_YELLOW, EW_YELLOW: d = YEL_C;
      default:              d = AR_C;
    endcase
    return d;
  endfunction

  always_comb begin
    qual = tick & ~hold;
    done = 1'b0;
    bad  = 1'b0;
    unique case (phase_q)
      NS_GREEN:
        done = (rem_q == ONE_C) ||
               ((rem_q <= EARLY_C) &&
                (car_ew | pend_ew));
      EW_GREEN:
        done = (rem_q == ONE_C) ||
               ((rem_q <= EARLY_C) &&
                (car_ns | pend_ns));
      NS_YELLOW, ALL_RED_A,
      EW_YELLOW, ALL_RED_B:
        done = (rem_q == ONE_C);
      default:
        bad = 1'b1;
    endcase

    phase_d = phase_q;
    rem_d   = rem_q;
    adv_d   = 1'b0;
    // Illegal codes resync quietly, without an advance pulse.
    if (bad) begin
      phase_d = NS_GREEN;
      rem_d   = MAX_C;
    end else if (qual && done) begin
      phase_d = next_phase(phase_q);
      rem_d   = dwell(phase_d);
      adv_d   = 1'b1;
    end else if (qual) begin
      rem_d   = rem_q - ONE_C;
    end

    grant_ns = adv_d & (phase_d == NS_GREEN);
    grant_ew = adv_d & (phase_d == EW_GREEN);
    leave_ns = adv_d & (phase_q == NS_GREEN);
    leave_ew = adv_d & (phase_q == EW_GREEN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= NS_GREEN;
      rem_q   <= MAX_C;
      adv_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      adv_q   <= adv_d;
    end
  end

  ped_latch u_ped_ns (
    .clk     (clk),
    .reset   (reset),
    .press   (ped_ns),
    .grant   (grant_ns),
    .leave   (leave_ns),
    .pending (pend_ns),
    .walk    (walk_ns)
  );

  ped_latch u_ped_ew (
    .clk     (clk),
    .reset   (reset),
    .press   (ped_ew),
    .grant   (grant_ew),
    .leave   (leave_ew),
    .pending (pend_ew),
    .walk    (walk_ew)
  );

  assign phase       = phase_q;
  assign remaining   = rem_q;
  assign advance     = adv_q;
  assign ped_pending = {pend_ew, pend_ns};

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed scenarios plus random
// stimulus, all checked against a tick-counting phase model.
module tb_traffic_phase_timer;

  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YT   = 2;
  localparam int ART  = 1;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          hold = 1'b0;
  logic          car_ns = 1'b0;
  logic          car_ew = 1'b0;
  logic          ped_ns = 1'b0;
  logic          ped_ew = 1'b0;
  logic [2:0]    phase;
  logic [CW-1:0] remaining;
  logic          advance;
  logic          walk_ns;
  logic          walk_ew;
  logic [1:0]    ped_pending;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  traffic_phase_timer #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (ART),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .hold        (hold),
    .car_ns      (car_ns),
    .car_ew      (car_ew),
    .ped_ns      (ped_ns),
    .ped_ew      (ped_ew),
    .phase       (phase),
    .remaining   (remaining),
    .advance     (advance),
    .walk_ns     (walk_ns),
    .walk_ew     (walk_ew),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  // Model: phase index and ticks already spent in it.
  int     m_ph = 0;
  int     m_el = 0;
  bit     m_adv = 0;
  bit [1:0] m_pend = 0;
  bit [1:0] m_walk = 0;

  function automatic int dur(input int p);
    if (p == 0 || p == 3) return GMAX;
    if (p == 1 || p == 4) return YT;
    return ART;
  endfunction

  always @(posedge clk) begin
    bit fin;
    bit q;
    int nph;
    int g;
    bit [1:0] pr;
    if (!reset) begin
      m_ph = 0; m_el = 0; m_adv = 0;
      m_pend = 0; m_walk = 0;
    end else begin
      pr  = {ped_ew, ped_ns};
      q   = tick && !hold;
      fin = 0;
      if (q) begin
        if (m_ph == 0)
          fin = (m_el + 1 == GMAX) ||
                (m_el + 1 >= GMIN &&
                 (car_ew || m_pend[1]));
        else if (m_ph == 3)
          fin = (m_el + 1 == GMAX) ||
                (m_el + 1 >= GMIN &&
                 (car_ns || m_pend[0]));
        else
          fin = (m_el + 1 == dur(m_ph));
      end
      nph = fin ? (m_ph + 1) % 6 : m_ph;
      for (int d = 0; d < 2; d++) begin
        g = (d == 1) ? 3 : 0;
        if (fin && nph == g) begin
          m_walk[d] = m_pend[d] | pr[d];
          m_pend[d] = 0;
        end else begin
          if (fin && m_ph == g) m_walk[d] = 0;
          m_pend[d] = m_pend[d] | pr[d];
        end
      end
      m_adv = fin;
      if (fin) begin
        m_ph = nph;
        m_el = 0;
      end else if (q) begin
        m_el = m_el + 1;
      end
    end
  end

  always @(posedge clk) begin
    int er;
    #1;
    if (chk_en) begin
      er = dur(m_ph) - m_el;
      n_tot++;
      if (int'(phase) == m_ph &&
          int'(remaining) == er &&
          advance == m_adv &&
          walk_ns == m_walk[0] &&
          walk_ew == m_walk[1] &&
          ped_pending == m_pend)
        n_pass++;
      else
        $display({"FAIL model t=%0t got ph=%0d rem=%0d ",
                  "adv=%0b walk=%0b%0b pend=%b; ",
                  "want ph=%0d rem=%0d adv=%0b ",
                  "walk=%0b%0b pend=%b"},
                 $time, phase, remaining, advance,
                 walk_ew, walk_ns, ped_pending,
                 m_ph, er, m_adv,
                 m_walk[1], m_walk[0], m_pend);
    end
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d want %0d",
                  nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_ph"}, phase, 0);
    chk({nm, "_rem"}, remaining, GMAX);
    chk({nm, "_adv"}, advance, 0);
    chk({nm, "_walk"}, {walk_ew, walk_ns}, 0);
    chk({nm, "_pend"}, ped_pending, 0);
  endtask

  task automatic do_rst();
    reset = 1'b0;
    tick = 1'b0; hold = 1'b0;
    ped_ns = 1'b0; ped_ew = 1'b0;
    cyc();
    chk_rst("rst");
    reset = 1'b1;
  endtask

  initial begin
    int n_adv;
    int frz;
    cyc();
    cyc();
    chk_en = 1'b1;

    // 1: idle cycle, no demand
    do_rst();
    tick = 1'b1;
    n_adv = 0;
    for (int i = 0; i < 22; i++) begin
      cyc();
      if (advance) n_adv++;
      if (i == 7) begin
        chk("t1_ph8", phase, 1);
        chk("t1_rem8", remaining, 2);
      end
    end
    chk("t1_nadv", n_adv, 6);
    chk("t1_ph", phase, 0);
    chk("t1_rem", remaining, 8);

    // 2: cross traffic ends green at min
    car_ew = 1'b1;
    do_rst();
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 2) chk("t2_ph3", phase, 0);
    end
    chk("t2_ph", phase, 1);
    chk("t2_rem", remaining, 2);
    chk("t2_adv", advance, 1);
    car_ew = 1'b0;

    // 3: EW pedestrian request
    do_rst();
    tick = 1'b1;
    cyc();
    ped_ew = 1'b1;
    cyc();
    ped_ew = 1'b0;
    chk("t3_pend", ped_pending, 2);
    cyc();
    cyc();
    chk("t3_ph1", phase, 1);
    repeat (3) cyc();
    chk("t3_ph3", phase, 3);
    chk("t3_walk", walk_ew, 1);
    chk("t3_pend0", ped_pending, 0);
    repeat (7) cyc();
    chk("t3_walkmid", walk_ew, 1);
    cyc();
    chk("t3_ph4", phase, 4);
    chk("t3_walkoff", walk_ew, 0);

    // 4: hold in NS_YELLOW
    do_rst();
    tick = 1'b1;
    repeat (8) cyc();
    chk("t4_ph", phase, 1);
    chk("t4_rem", remaining, 2);
    hold = 1'b1;
    frz = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (phase != 1 || remaining != 2 || advance)
        frz++;
    end
    chk("t4_frozen", frz, 0);
    hold = 1'b0;
    cyc();
    chk("t4_rem1", remaining, 1);
    cyc();
    chk("t4_ar", phase, 2);

    // 5: reset mid EW_GREEN with a pending press
    cyc();
    chk("t5_ew", phase, 3);
    tick = 1'b0;
    ped_ew = 1'b1;
    cyc();
    ped_ew = 1'b0;
    chk("t5_pend", ped_pending, 2);
    reset = 1'b0;
    tick = 1'b1;
    ped_ns = 1'b1;
    cyc();
    chk_rst("t5");
    reset = 1'b1;
    ped_ns = 1'b0;

    // 6: press on the tick that enters NS_GREEN
    car_ns = 1'b1;
    car_ew = 1'b1;
    repeat (13) cyc();
    chk("t6_ar", phase, 5);
    ped_ns = 1'b1;
    cyc();
    ped_ns = 1'b0;
    chk("t6_ph", phase, 0);
    chk("t6_adv", advance, 1);
    chk("t6_walk", walk_ns, 1);
    chk("t6_pend", ped_pending[0], 0);
    car_ns = 1'b0;
    car_ew = 1'b0;
    cyc();
    cyc();
    chk("t6_walk2", walk_ns, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 299) != 0);
      tick   = ($urandom_range(0, 2) != 0);
      hold   = ($urandom_range(0, 7) == 0);
      ped_ns = ($urandom_range(0, 11) == 0);
      ped_ew = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0)
        car_ns = ~car_ns;
      if ($urandom_range(0, 19) == 0)
        car_ew = ~car_ew;
      cyc();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
